// File: rtl/eq_pkg.sv
// Shared constants and types for the divider: default operand width and FSM state encoding.
package eq_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider.sv
// Iterative signed divider: one restoring step per cycle on operand magnitudes,
// sign correction and saturation applied once when the result is committed.
module divider
    import eq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int               CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [WIDTH-1:0] Q_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MIN     = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH:0]   bm_reg;
    logic [WIDTH-1:0] dq_reg;
    logic [WIDTH-1:0] a_reg;
    logic             a_neg_reg;
    logic             b_neg_reg;
    logic             dbz_pend_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dbz_reg;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] dq_next;
    logic             q_neg;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        a_abs = a[WIDTH-1] ? -a : a;
        b_abs = b[WIDTH-1] ? -b : b;

        // Shift the next dividend bit into the partial remainder and trial-subtract.
        diff = {rem_reg, dq_reg[WIDTH-1]} - {1'b0, bm_reg};
        if (!diff[WIDTH+1]) begin
            rem_next = diff[WIDTH:0];
            dq_next  = {dq_reg[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = {rem_reg[WIDTH-1:0], dq_reg[WIDTH-1]};
            dq_next  = {dq_reg[WIDTH-2:0], 1'b0};
        end

        // A positive quotient with the top bit set only arises from MIN / -1.
        q_neg = a_neg_reg ^ b_neg_reg;
        if (!q_neg && dq_reg[WIDTH-1]) begin
            q_fix = Q_MAX;
        end else begin
            q_fix = q_neg ? -dq_reg : dq_reg;
        end
        r_fix = a_neg_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            rem_reg      <= '0;
            bm_reg       <= '0;
            dq_reg       <= '0;
            a_reg        <= '0;
            a_neg_reg    <= 1'b0;
            b_neg_reg    <= 1'b0;
            dbz_pend_reg <= 1'b0;
            q_reg        <= '0;
            r_reg        <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            dbz_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg    <= CALC;
                        cnt_reg      <= '0;
                        rem_reg      <= '0;
                        bm_reg       <= {1'b0, b_abs};
                        dq_reg       <= a_abs;
                        a_reg        <= a;
                        a_neg_reg    <= a[WIDTH-1];
                        b_neg_reg    <= b[WIDTH-1];
                        dbz_pend_reg <= (b == '0);
                        busy_reg     <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    if (dbz_pend_reg) begin
                        // Zero divisor: no iterations, result committed on the next edge.
                        state_reg <= DONE;
                        q_reg     <= a_neg_reg ? Q_MIN : Q_MAX;
                        r_reg     <= a_reg;
                        dbz_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (cnt_reg == LAST_STEP) begin
                        state_reg <= DONE;
                        q_reg     <= q_fix;
                        r_reg     <= r_fix;
                        dbz_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        rem_reg <= rem_next;
                        dq_reg  <= dq_next;
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = q_reg;
    assign r    = r_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign dbz  = dbz_reg;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divider: directed corner cases, random operands against
// an integer-arithmetic reference, ignored starts, reset abort and result hold.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        busy;
    logic        done;
    logic        dbz;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    divider #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    // Reference: plain integer division truncating toward zero, remainder follows dividend.
    function automatic void model(input int av, input int bv, output logic [15:0] eq,
                                  output logic [15:0] er, output logic ed, output int el);
        if (bv == 0) begin
            eq = (av >= 0) ? 16'h7FFF : 16'h8000;
            er = 16'(av);
            ed = 1'b1;
            el = 1;
        end else if (av == -32768 && bv == -1) begin
            eq = 16'h7FFF;
            er = 16'h0000;
            ed = 1'b0;
            el = 17;
        end else begin
            eq = 16'(av / bv);
            er = 16'(av % bv);
            ed = 1'b0;
            el = 17;
        end
    endfunction

    // Issue one start and count edges until done; bounded at 40 edges.
    task automatic do_op(input int av, input int bv, output int lat, output logic busy_seen);
        @(negedge clk);
        a = 16'(av);
        b = 16'(bv);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_seen = busy;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        n_vec++;
        if ({q, r, busy, done, dbz} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_state got q=%h r=%h busy=%b done=%b dbz=%b exp all 0", q, r, busy, done, dbz);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed;
        int          av_t [8] = '{100, -64, 81, -29858, 7, -7, -32768, -32768};
        int          bv_t [8] = '{10, 8, -9, 8, 0, 0, -1, 1};
        logic [15:0] eq, er;
        logic        ed, bs;
        int          el, lat;
        // Consecutive operations start in the previous DONE cycle, exercising back-to-back.
        for (int i = 0; i < 8; i++) begin
            do_op(av_t[i], bv_t[i], lat, bs);
            model(av_t[i], bv_t[i], eq, er, ed, el);
            $display("directed a=%0d b=%0d -> q=%0d r=%0d dbz=%b lat=%0d",
                     av_t[i], bv_t[i], $signed(q), $signed(r), dbz, lat);
            n_vec++;
            if (lat !== el) begin
                n_err++;
                $display("FAIL directed_latency a=%0d b=%0d got=%0d exp=%0d", av_t[i], bv_t[i], lat, el);
            end
            n_vec++;
            if ({q, r, dbz} !== {eq, er, ed}) begin
                n_err++;
                $display("FAIL directed_result a=%0d b=%0d got q=%h r=%h dbz=%b exp q=%h r=%h dbz=%b",
                         av_t[i], bv_t[i], q, r, dbz, eq, er, ed);
            end
            n_vec++;
            if (bs !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL directed_busy a=%0d b=%0d got busy_after_start=%b busy_at_done=%b exp 1/0",
                         av_t[i], bv_t[i], bs, busy);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] eq, er;
        logic        ed, bs;
        int          av, bv, el, lat;
        for (int i = 0; i < 30; i++) begin
            av = int'($urandom_range(0, 65535)) - 32768;
            if (i % 5 == 0)
                bv = 0;
            else if (i % 4 == 1)
                bv = int'($urandom_range(0, 30)) - 15;
            else
                bv = int'($urandom_range(0, 65535)) - 32768;
            do_op(av, bv, lat, bs);
            model(av, bv, eq, er, ed, el);
            $display("random a=%0d b=%0d -> q=%0d r=%0d dbz=%b lat=%0d",
                     av, bv, $signed(q), $signed(r), dbz, lat);
            n_vec++;
            if (lat !== el || {q, r, dbz} !== {eq, er, ed}) begin
                n_err++;
                $display("FAIL random a=%0d b=%0d got q=%h r=%h dbz=%b lat=%0d exp q=%h r=%h dbz=%b lat=%0d",
                         av, bv, q, r, dbz, lat, eq, er, ed, el);
            end
        end
    endtask

    task automatic test_hold;
        logic [15:0] eq, er;
        logic        ed, bs;
        int          el, lat;
        do_op(-1234, 56, lat, bs);
        model(-1234, 56, eq, er, ed, el);
        repeat (5) @(posedge clk);
        #1;
        $display("hold a=-1234 b=56 -> q=%0d r=%0d done=%b", $signed(q), $signed(r), done);
        n_vec++;
        if ({q, r, dbz, done} !== {eq, er, ed, 1'b0}) begin
            n_err++;
            $display("FAIL hold got q=%h r=%h dbz=%b done=%b exp q=%h r=%h dbz=%b done=0",
                     q, r, dbz, done, eq, er, ed);
        end
    endtask

    task automatic test_ignore_start;
        int lat = 0;
        bit got = 0;
        @(negedge clk);
        a = 16'd1000;
        b = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (i == 3 || i == 10) begin
                start = 1'b1;
                a = 16'($urandom);
                b = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat = i;
            if (done === 1'b1) got = 1;
        end
        start = 1'b0;
        $display("ignore_start a=1000 b=7 -> q=%0d r=%0d lat=%0d", $signed(q), $signed(r), lat);
        n_vec++;
        if (lat !== 17 || {q, r, dbz} !== {16'd142, 16'd6, 1'b0}) begin
            n_err++;
            $display("FAIL ignore_start got q=%h r=%h dbz=%b lat=%0d exp q=008e r=0006 dbz=0 lat=17",
                     q, r, dbz, lat);
        end
    endtask

    task automatic test_reset_abort;
        bit          seen = 0;
        logic        bs;
        int          lat;
        @(negedge clk);
        a = 16'd12345;
        b = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_busy_before got=%b exp=1", busy);
        end
        rst = 1'b0;
        #1;
        $display("abort q=%h r=%h busy=%b done=%b dbz=%b", q, r, busy, done, dbz);
        n_vec++;
        if ({q, r, busy, done, dbz} !== 35'd0) begin
            n_err++;
            $display("FAIL abort_outputs got q=%h r=%h busy=%b done=%b dbz=%b exp all 0", q, r, busy, done, dbz);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done got done_seen=%b exp=0", seen);
        end
        do_op(9, 2, lat, bs);
        $display("after_abort a=9 b=2 -> q=%0d r=%0d lat=%0d", $signed(q), $signed(r), lat);
        n_vec++;
        if (lat !== 17 || {q, r, dbz} !== {16'd4, 16'd1, 1'b0}) begin
            n_err++;
            $display("FAIL after_abort got q=%h r=%h dbz=%b lat=%0d exp q=0004 r=0001 dbz=0 lat=17",
                     q, r, dbz, lat);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_hold;
        test_ignore_start;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
